// File: rtl/layer_pkg.sv
// ============================================================================
//  Module      : layer_pkg
//  Description : Shared layer parameters, pixel type and pooling FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_pkg;

    localparam int IMG_W_DEF = 32;
    localparam int IMG_H_DEF = 32;
    localparam int DW        = 8;

    typedef logic signed [DW-1:0] pixel_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : layer_pkg

`default_nettype wire

// File: rtl/pool_linebuf.sv
// ============================================================================
//  Module      : pool_linebuf
//  Description : Half-row line buffer of horizontal maxima; one write port and
//                one combinational read port sharing a single address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_linebuf #(
    parameter int DEPTH = 16,
    parameter int DW    = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents are always written on an even row before being read on the
    // following odd row, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : pool_linebuf

`default_nettype wire

// File: rtl/pool2x2_stage.sv
// ============================================================================
//  Module      : pool2x2_stage
//  Description : Stride-2 2x2 signed max-pool over a raster pixel stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool2x2_stage
    import layer_pkg::*;
#(
    parameter int IMG_W = layer_pkg::IMG_W_DEF,
    parameter int IMG_H = layer_pkg::IMG_H_DEF,
    parameter int DW    = layer_pkg::DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          iStart,
    input  logic          iVld,
    input  logic [DW-1:0] iDin,
    output logic          oVld,
    output logic [DW-1:0] oDout,
    output logic          oFrameDone,
    output logic          oBusy
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] C_LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_LAST_ROW = RW'(IMG_H - 1);

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] col_q,   col_d;
    logic [RW-1:0] row_q,   row_d;
    logic [DW-1:0] hold_q,  hold_d;
    logic          vld_q,   vld_d;
    logic [DW-1:0] dout_q,  dout_d;
    logic          done_q,  done_d;

    logic          w_accept;
    logic [DW-1:0] w_hmax;
    logic [DW-1:0] w_lb_rd;
    logic          w_lb_we;
    logic [AW-1:0] w_lb_addr;

    // A start pulse outranks a coincident pixel, which is simply dropped.
    assign w_accept  = iVld && (state_q == RUN) && !iStart;
    assign w_hmax    = smax(hold_q, iDin);
    assign w_lb_addr = AW'(col_q >> 1);

    pool_linebuf #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_linebuf (
        .clk     (clk),
        .we_i    (w_lb_we),
        .addr_i  (w_lb_addr),
        .wdata_i (w_hmax),
        .rdata_o (w_lb_rd)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        vld_d   = 1'b0;
        dout_d  = dout_q;
        done_d  = 1'b0;
        w_lb_we = 1'b0;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (iStart) begin
                    col_d = '0;
                    row_d = '0;
                end else if (w_accept) begin
                    if (!col_q[0]) begin
                        hold_d = iDin;
                    end else if (!row_q[0]) begin
                        w_lb_we = 1'b1;
                    end else begin
                        vld_d  = 1'b1;
                        dout_d = smax(w_lb_rd, w_hmax);
                    end

                    if (col_q == C_LAST_COL) begin
                        col_d = '0;
                        if (row_q == C_LAST_ROW) begin
                            row_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            vld_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign oVld       = vld_q;
    assign oDout      = dout_q;
    assign oFrameDone = done_q;
    assign oBusy      = (state_q == RUN);

endmodule : pool2x2_stage

`default_nettype wire

// File: tb/tb_pool2x2_stage.sv
// ============================================================================
//  Module      : tb_pool2x2_stage
//  Description : Self-checking bench for pool2x2_stage on a 4x4 feature map.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pool2x2_stage;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int NPX = W * H;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          iStart = 1'b0;
    logic          iVld   = 1'b0;
    logic [DW-1:0] iDin   = '0;
    logic          oVld;
    logic [DW-1:0] oDout;
    logic          oFrameDone;
    logic          oBusy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pool2x2_stage #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .iStart     (iStart),
        .iVld       (iVld),
        .iDin       (iDin),
        .oVld       (oVld),
        .oDout      (oDout),
        .oFrameDone (oFrameDone),
        .oBusy      (oBusy)
    );

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: remembers every accepted pixel of the frame by raster
    // index and pools each 2x2 window directly from that picture.
    int                   img [NPX];
    int                   m_n      = 0;
    bit                   m_busy   = 0;
    bit                   exp_vld  = 0;
    bit                   exp_done = 0;
    int                   exp_dout = 0;

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        int r, c;
        if (!rstn) begin
            m_n = 0; m_busy = 0; exp_vld = 0; exp_done = 0; exp_dout = 0;
        end else begin
            exp_vld  = 0;
            exp_done = 0;
            if (iStart) begin
                m_busy = 1;
                m_n    = 0;
            end else if (iVld && m_busy) begin
                r = m_n / W;
                c = m_n % W;
                img[m_n] = int'($signed(iDin));
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    exp_vld  = 1;
                    exp_dout = mx(mx(img[(r-1)*W + c-1], img[(r-1)*W + c]),
                                  mx(img[r*W + c-1],     img[r*W + c]));
                end
                m_n++;
                if (m_n == NPX) begin
                    exp_done = 1;
                    m_busy   = 0;
                    m_n      = 0;
                end
            end
        end
    end

    int got_q [$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (rstn) begin
            chk("oVld", int'(oVld), int'(exp_vld));
            if (exp_vld) chk("oDout", int'($signed(oDout)), exp_dout);
            chk("oFrameDone", int'(oFrameDone), int'(exp_done));
            chk("oBusy", int'(oBusy), int'(m_busy));
            if (oVld) got_q.push_back(int'($signed(oDout)));
            if (oFrameDone) done_cnt++;
        end
    end

    int pat [NPX];

    task automatic px(input bit st, input bit v, input int d);
        @(negedge clk);
        iStart = st;
        iVld   = v;
        iDin   = d[DW-1:0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(0, 0, $urandom);
    endtask

    task automatic send_pixels(input int first, input int last, input int gap_pct);
        for (int i = first; i <= last; i++) begin
            while (int'($urandom_range(99)) < gap_pct) px(0, 0, $urandom);
            px(0, 1, pat[i]);
        end
        idle(3);
    endtask

    task automatic expect4(input string nm, input int base, input int a,
                           input int b, input int c, input int d);
        int e [4];
        e = '{a, b, c, d};
        chk({nm, " count"}, got_q.size() - base, 4);
        if (got_q.size() >= base + 4)
            for (int k = 0; k < 4; k++) chk({nm, " value"}, got_q[base + k], e[k]);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int base, dbase, cut, frames;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset oVld", int'(oVld), 0);
        chk("reset oDout", int'(oDout), 0);
        chk("reset oFrameDone", int'(oFrameDone), 0);
        chk("reset oBusy", int'(oBusy), 0);
        rstn = 1'b1;

        // Pixels without a start pulse are ignored
        for (int i = 0; i < 8; i++) px(0, i % 2 == 0, i);
        idle(2);
        chk("idle no output", got_q.size(), 0);
        chk("idle busy", int'(oBusy), 0);

        // Ramp 0..15, continuous
        for (int i = 0; i < NPX; i++) pat[i] = i;
        base = got_q.size(); dbase = done_cnt;
        px(1, 0, 0);
        send_pixels(0, NPX - 1, 0);
        expect4("ramp", base, 5, 7, 13, 15);
        chk("ramp done count", done_cnt - dbase, 1);
        chk("ramp busy after", int'(oBusy), 0);

        // Signed: all -128 except (row 1, col 2) = -1
        for (int i = 0; i < NPX; i++) pat[i] = -128;
        pat[1*W + 2] = -1;
        base = got_q.size();
        px(1, 0, 0);
        send_pixels(0, NPX - 1, 0);
        expect4("signed", base, -128, -1, -128, -128);

        // Gapped ramp
        for (int i = 0; i < NPX; i++) pat[i] = i;
        base = got_q.size(); dbase = done_cnt;
        px(1, 0, 0);
        send_pixels(0, NPX - 1, 40);
        expect4("gapped", base, 5, 7, 13, 15);
        chk("gapped done count", done_cnt - dbase, 1);

        // Restart: five pixels, then a start pulse coinciding with a pixel
        base = got_q.size(); dbase = done_cnt;
        px(1, 0, 0);
        for (int i = 0; i < 5; i++) px(0, 1, 100 + i);
        px(1, 1, 105);
        send_pixels(0, NPX - 1, 0);
        expect4("restart", base, 5, 7, 13, 15);
        chk("restart done count", done_cnt - dbase, 1);

        // Async reset in row 3 while an output is being presented
        px(1, 0, 0);
        for (int i = 0; i < 14; i++) px(0, 1, pat[i]);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("areset oVld", int'(oVld), 0);
        chk("areset oDout", int'(oDout), 0);
        chk("areset oFrameDone", int'(oFrameDone), 0);
        chk("areset oBusy", int'(oBusy), 0);
        @(negedge clk);
        iVld = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 6; i++) px(0, 1, 50 + i);
        idle(2);
        chk("post-reset ignored", got_q.size() - base, 0);
        dbase = done_cnt;
        px(1, 0, 0);
        send_pixels(0, NPX - 1, 0);
        expect4("post-reset", base, 5, 7, 13, 15);
        chk("post-reset done count", done_cnt - dbase, 1);

        // Random frames, random gaps, occasional aborts
        dbase  = done_cnt;
        frames = 0;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NPX; i++) pat[i] = $urandom;
            px(1, 0, 0);
            if ($urandom_range(3) == 0) begin
                cut = $urandom_range(NPX - 2);
                for (int i = 0; i <= cut; i++) px(0, 1, $urandom);
                px(1, $urandom_range(1), $urandom);
            end
            send_pixels(0, NPX - 1, $urandom_range(60));
            frames++;
        end
        chk("random done count", done_cnt - dbase, frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pool2x2_stage

`default_nettype wire
